// File: rtl/booth_div_seq.sv
// booth_div_seq: sequential signed restoring divider (one quotient bit per cycle) with valid/ready handshakes
module booth_div_seq #(
    parameter int WIDTH_N = 8,
    parameter int WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               dbz,
    output logic               ovf
);
    localparam int CW = $clog2(WIDTH_N);
    localparam logic [CW-1:0] LAST = CW'(WIDTH_N - 1);
    localparam logic [WIDTH_N-1:0] MIN_N = {1'b1, {(WIDTH_N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH_N-1:0] qreg;
    logic [WIDTH_D:0]   prem, dvs_mag;
    logic [CW-1:0]      cnt;
    logic               sign_n, sign_d, dbz_r, ovf_r;
    logic [WIDTH_N-1:0] dnd_abs;
    logic [WIDTH_D-1:0] dvs_abs;
    logic [WIDTH_D+1:0] shifted, trial;
    logic               qbit, accept;

    // Magnitudes fit unsigned in the operand width, so min_neg needs no extra bit here
    assign dnd_abs = dividend[WIDTH_N-1] ? -dividend : dividend;
    assign dvs_abs = divisor[WIDTH_D-1] ? -divisor : divisor;
    assign shifted = {prem, qreg[WIDTH_N-1]};
    assign trial   = shifted - {1'b0, dvs_mag};
    // With a zero divisor every step "succeeds", so prem just collects the dividend magnitude bits
    assign qbit    = dbz_r | ~trial[WIDTH_D+1];
    assign accept  = in_vld && in_rdy;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) state_nxt = CALC;
            end
            CALC: if (cnt == LAST) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                out_vld = 1'b1;
                if (out_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, shift-subtract iteration and sign fix-up of the results
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            qreg      <= '0;
            prem      <= '0;
            dvs_mag   <= '0;
            cnt       <= '0;
            sign_n    <= 1'b0;
            sign_d    <= 1'b0;
            dbz_r     <= 1'b0;
            ovf_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                qreg    <= dnd_abs;
                dvs_mag <= {1'b0, dvs_abs};
                sign_n  <= dividend[WIDTH_N-1];
                sign_d  <= divisor[WIDTH_D-1];
                dbz_r   <= divisor == '0;
                ovf_r   <= dividend == MIN_N && divisor == '1;
                prem    <= '0;
                cnt     <= '0;
            end
            if (state == CALC) begin
                qreg <= {qreg[WIDTH_N-2:0], qbit};
                prem <= qbit ? trial[WIDTH_D:0] : shifted[WIDTH_D:0];
                cnt  <= cnt + 1'b1;
            end
            if (state == FIX) begin
                quotient  <= dbz_r ? '1 : ovf_r ? MIN_N : (sign_n ^ sign_d) ? -qreg : qreg;
                remainder <= ovf_r ? '0 : sign_n ? -prem[WIDTH_D-1:0] : prem[WIDTH_D-1:0];
                dbz       <= dbz_r;
                ovf       <= ovf_r;
            end
        end
    end
endmodule

// File: tb/tb_booth_div_seq.sv
// tb_booth_div_seq: directed and random checks of booth_div_seq (8/8 and 16/8) against an arithmetic reference
module tb_booth_div_seq;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8, or8, dz8, of8;
    logic [7:0] n8, d8, q8, r8;
    logic        iv16, ir16, ov16, or16, dz16, of16;
    logic [15:0] n16, q16;
    logic [7:0]  d16, r16;

    booth_div_seq #(.WIDTH_N(8), .WIDTH_D(8)) u8 (
        .clk(clk), .rstn(rstn), .in_vld(iv8), .in_rdy(ir8), .dividend(n8), .divisor(d8),
        .out_vld(ov8), .out_rdy(or8), .quotient(q8), .remainder(r8), .dbz(dz8), .ovf(of8)
    );
    booth_div_seq #(.WIDTH_N(16), .WIDTH_D(8)) u16 (
        .clk(clk), .rstn(rstn), .in_vld(iv16), .in_rdy(ir16), .dividend(n16), .divisor(d16),
        .out_vld(ov16), .out_rdy(or16), .quotient(q16), .remainder(r16), .dbz(dz16), .ovf(of16)
    );

    logic        sel;
    logic [15:0] oq;
    logic [7:0]  orr;
    logic        oir, oov, odz, oof;
    assign oq  = sel ? q16 : {8'h00, q8};
    assign orr = sel ? r16 : r8;
    assign oir = sel ? ir16 : ir8;
    assign oov = sel ? ov16 : ov8;
    assign odz = sel ? dz16 : dz8;
    assign oof = sel ? of16 : of8;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic w, input logic [15:0] n, input logic [7:0] d,
                                    output logic [15:0] q, output logic [7:0] r,
                                    output logic z, output logic o);
        longint sn, sd, mn, qq, rr;
        sn = w ? longint'($signed(n)) : longint'($signed(n[7:0]));
        sd = longint'($signed(d));
        mn = w ? -32768 : -128;
        z  = (sd == 0);
        o  = (sn == mn && sd == -1);
        if (z) begin
            qq = -1;
            rr = sn;
        end else if (o) begin
            qq = mn;
            rr = 0;
        end else begin
            qq = sn / sd;
            rr = sn % sd;
        end
        q = w ? qq[15:0] : {8'h00, qq[7:0]};
        r = rr[7:0];
    endfunction

    task automatic drive(input logic v, input logic [15:0] n, input logic [7:0] d);
        if (sel) begin
            iv16 = v; n16 = n; d16 = d;
        end else begin
            iv8 = v; n8 = n[7:0]; d8 = d;
        end
    endtask

    task automatic set_rdy(input logic r);
        if (sel) or16 = r;
        else or8 = r;
    endtask

    task automatic op(input logic w, input logic [15:0] n, input logic [7:0] d, input int hold);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez, eo;
        int          edges, guard;
        sel = w;
        ref_div(w, n, d, eq, er, ez, eo);
        @(negedge clk);
        drive(1'b1, n, d);
        guard = 0;
        while (!oir && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("accept_timeout", 32'(guard), 32'(0));
        @(posedge clk);
        #1 drive(1'b0, 16'($urandom), 8'($urandom));
        edges = 1;
        while (!oov && edges < 60) begin
            @(posedge clk);
            #1 edges++;
        end
        chk("latency", 32'(edges), w ? 32'(18) : 32'(10));
        chk("quotient", 32'(oq), 32'(eq));
        chk("remainder", 32'(orr), 32'(er));
        chk("dbz", 32'(odz), 32'(ez));
        chk("ovf", 32'(oof), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive(1'b1, 16'($urandom), 8'($urandom));
            @(posedge clk);
            #1;
            chk("hold_vld", 32'(oov), 32'(1));
            chk("hold_rdy", 32'(oir), 32'(0));
            chk("hold_q", 32'(oq), 32'(eq));
            chk("hold_r", 32'(orr), 32'(er));
        end
        @(negedge clk);
        drive(1'b0, 16'($urandom), 8'($urandom));
        set_rdy(1'b1);
        @(posedge clk);
        #1 set_rdy(1'b0);
        chk("handoff_vld", 32'(oov), 32'(0));
        chk("handoff_rdy", 32'(oir), 32'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rn;
        logic [7:0]  rd;
        sel = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; n8 = '0; d8 = '0;
        iv16 = 1'b0; or16 = 1'b0; n16 = '0; d16 = '0;
        #2;
        chk("rst_rdy", 32'(oir), 32'(1));
        chk("rst_vld", 32'(oov), 32'(0));
        chk("rst_q", 32'(oq), 32'(0));
        chk("rst_r", 32'(orr), 32'(0));
        chk("rst_dbz", 32'(odz), 32'(0));
        chk("rst_ovf", 32'(oof), 32'(0));
        @(negedge clk);
        rstn = 1'b1;

        op(1'b0, 16'(100), 8'(7), 0);
        op(1'b0, 16'(-100), 8'(7), 0);
        op(1'b0, 16'(100), 8'(-7), 0);
        op(1'b0, 16'(-100), 8'(-7), 0);
        op(1'b0, 16'(-128), 8'(-1), 0);
        op(1'b0, 16'(-128), 8'(1), 0);
        op(1'b0, 16'(55), 8'(0), 0);
        op(1'b0, 16'(3), 8'(2), 0);
        op(1'b0, 16'(100), 8'(7), 5);

        sel = 1'b0;
        @(negedge clk);
        drive(1'b1, 16'(50), 8'(3));
        @(posedge clk);
        #1 drive(1'b0, 16'(0), 8'(0));
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("abort_vld", 32'(oov), 32'(0));
        chk("abort_rdy", 32'(oir), 32'(1));
        chk("abort_q", 32'(oq), 32'(0));
        chk("abort_r", 32'(orr), 32'(0));
        chk("abort_dbz", 32'(odz), 32'(0));
        chk("abort_ovf", 32'(oof), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        op(1'b0, 16'(127), 8'(127), 0);

        op(1'b1, 16'h8000, 8'hFF, 0);
        op(1'b1, 16'(-1234), 8'(0), 0);
        op(1'b1, 16'h7FFF, 8'h80, 0);
        for (int k = 0; k < 40; k++) begin
            rn = 16'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            op(1'b1, rn, rd, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
